// File: rtl/mips_mc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_mc_ctrl_pkg
// Shared definitions for the multicycle MIPS main controller: opcode and funct
// constants, ALU alternate-control codes, the controller state enum and the
// packed bundle of Moore control outputs.
// -----------------------------------------------------------------------------
package mips_mc_ctrl_pkg;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP6_RTYPE = 6'b000000;
    localparam logic [5:0] OP6_LW    = 6'b100011;
    localparam logic [5:0] OP6_SW    = 6'b101011;
    localparam logic [5:0] OP6_BEQ   = 6'b000100;
    localparam logic [5:0] OP6_BNE   = 6'b000101;
    localparam logic [5:0] OP6_ADDI  = 6'b001000;
    localparam logic [5:0] OP6_J     = 6'b000010;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FUNCT6_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT6_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT6_AND  = 6'b100100;
    localparam logic [5:0] FUNCT6_OR   = 6'b100101;
    localparam logic [5:0] FUNCT6_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT6_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT6_SRL  = 6'b000010;
    // Idle code: tells the ALU to obey the alternate control instead. It
    // cannot be 000000 because that encodes SLL.
    localparam logic [5:0] FUNCT6_NONE = 6'b111111;

    // ALU alternate control
    localparam logic [1:0] ALU_ADD_ALT = 2'b00;
    localparam logic [1:0] ALU_SUB_ALT = 2'b01;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } mc_state_t;

    typedef struct packed {
        logic [5:0] alu_funct;
        logic [1:0] alu_alt;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       iord;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       pc_write;
        logic       branch;
    } mc_ctrl_t;

    function automatic logic funct_supported(input logic [5:0] funct);
        case (funct)
            FUNCT6_ADD, FUNCT6_SUB, FUNCT6_AND, FUNCT6_OR,
            FUNCT6_SLT, FUNCT6_SLL, FUNCT6_SRL: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_mc_ctrl_outdec.sv
// -----------------------------------------------------------------------------
// mips_mc_outdec
// Purely combinational Moore output decoder: maps the controller state (and,
// in EXECUTE, the instruction funct field) onto the full control bundle.
// Ports:
//   i_state  - current controller state
//   i_funct  - instr[5:0], forwarded to the ALU only in EXECUTE
//   o_ctrl   - decoded control outputs
// -----------------------------------------------------------------------------
module mips_mc_outdec
    import mips_mc_ctrl_pkg::*;
(
    input  mc_state_t  i_state,
    input  logic [5:0] i_funct,
    output mc_ctrl_t   o_ctrl
);

    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves
        // a field unassigned, which would otherwise infer a latch.
        o_ctrl           = '0;
        o_ctrl.alu_funct = FUNCT6_NONE;
        o_ctrl.alu_alt   = ALU_ADD_ALT;
        case (i_state)
            S_FETCH: begin
                o_ctrl.ir_write  = 1'b1;
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.alu_src_b = 2'b01;
            end
            S_DECODE: begin
                // Branch target PC + (imm << 2) is parked in ALUOut here.
                o_ctrl.alu_src_b = 2'b11;
            end
            S_MEMADR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                o_ctrl.iord = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                o_ctrl.iord      = 1'b1;
                o_ctrl.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_funct = i_funct;
            end
            S_ALUWB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_alt   = ALU_SUB_ALT;
                o_ctrl.pc_src    = 2'b01;
                o_ctrl.branch    = 1'b1;
            end
            S_ADDIEX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                o_ctrl.reg_write = 1'b1;
            end
            S_JUMP: begin
                o_ctrl.pc_src   = 2'b10;
                o_ctrl.pc_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// -----------------------------------------------------------------------------
// mips_mc_ctrl
// Multicycle MIPS main controller. Moore FSM sequencing FETCH/DECODE/execute/
// memory/writeback; drives ALU control, datapath selects and write strobes.
// Optional feature: define MIPS_MC_BNE_EN to decode BNE (opcode 000101).
// Ports:
//   clk_i, rst_ni            - clock, async active-low reset
//   opcode_i6, funct_i6      - instruction fields from the IR
//   zero_i                   - ALU zero flag (same cycle)
//   alu_funct_o6, alu_alt_o2 - ALU function / alternate control
//   alu_src_a_o, alu_src_b_o2, pc_src_o2, iord_o, reg_dst_o, mem_to_reg_o
//                            - datapath selects
//   ir_write_o, mem_write_o, reg_write_o, pc_en_o - write strobes
//   illegal_o                - one-cycle pulse after an unsupported op/funct
//   state_o4                 - current state for debug
// -----------------------------------------------------------------------------
module mips_mc_ctrl
    import mips_mc_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [5:0] opcode_i6,
    input  logic [5:0] funct_i6,
    input  logic       zero_i,
    output logic [5:0] alu_funct_o6,
    output logic [1:0] alu_alt_o2,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o2,
    output logic [1:0] pc_src_o2,
    output logic       iord_o,
    output logic       ir_write_o,
    output logic       mem_write_o,
    output logic       reg_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       pc_en_o,
    output logic       illegal_o,
    output logic [3:0] state_o4
);

    mc_state_t r_state;
    mc_state_t w_state_next;
    logic      r_illegal;
    logic      w_illegal_next;
    // LW/SW split in MEMADR uses a flag captured in DECODE so the opcode is
    // never looked at outside DECODE.
    logic      r_mem_is_sw;
    logic      w_branch_cond;
    mc_ctrl_t  w_ctrl;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_ni) begin
            r_state     <= S_FETCH;
            r_illegal   <= 1'b0;
            r_mem_is_sw <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_illegal <= w_illegal_next;
            if (r_state == S_DECODE)
                r_mem_is_sw <= (opcode_i6 == OP6_SW);
        end
    end

`ifdef MIPS_MC_BNE_EN
    logic r_is_bne;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_is_bne <= 1'b0;
        else if (r_state == S_DECODE)
            r_is_bne <= (opcode_i6 == OP6_BNE);
    end

    assign w_branch_cond = zero_i ^ r_is_bne;
`else
    assign w_branch_cond = zero_i;
`endif

    always_comb begin
        w_state_next   = r_state;
        w_illegal_next = 1'b0;
        case (r_state)
            S_FETCH: w_state_next = S_DECODE;
            S_DECODE: begin
                case (opcode_i6)
                    OP6_LW, OP6_SW: w_state_next = S_MEMADR;
                    OP6_RTYPE:      w_state_next = S_EXECUTE;
                    OP6_BEQ:        w_state_next = S_BRANCH;
`ifdef MIPS_MC_BNE_EN
                    OP6_BNE:        w_state_next = S_BRANCH;
`endif
                    OP6_ADDI:       w_state_next = S_ADDIEX;
                    OP6_J:          w_state_next = S_JUMP;
                    default: begin
                        w_state_next   = S_FETCH;
                        w_illegal_next = 1'b1;
                    end
                endcase
            end
            S_MEMADR: w_state_next = r_mem_is_sw ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_state_next = S_MEMWB;
            S_EXECUTE: begin
                if (funct_supported(funct_i6)) begin
                    w_state_next = S_ALUWB;
                end else begin
                    w_state_next   = S_FETCH;
                    w_illegal_next = 1'b1;
                end
            end
            S_ADDIEX: w_state_next = S_ADDIWB;
            // MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP all retire here.
            default:  w_state_next = S_FETCH;
        endcase
    end

    mips_mc_outdec u_outdec (
        .i_state (r_state),
        .i_funct (funct_i6),
        .o_ctrl  (w_ctrl)
    );

    assign alu_funct_o6 = w_ctrl.alu_funct;
    assign alu_alt_o2   = w_ctrl.alu_alt;
    assign alu_src_a_o  = w_ctrl.alu_src_a;
    assign alu_src_b_o2 = w_ctrl.alu_src_b;
    assign pc_src_o2    = w_ctrl.pc_src;
    assign iord_o       = w_ctrl.iord;
    assign reg_dst_o    = w_ctrl.reg_dst;
    assign mem_to_reg_o = w_ctrl.mem_to_reg;
    // Strobes are gated by reset directly so an in-flight write is cut off
    // the moment reset asserts, not at the next edge.
    assign ir_write_o   = rst_ni & w_ctrl.ir_write;
    assign mem_write_o  = rst_ni & w_ctrl.mem_write;
    assign reg_write_o  = rst_ni & w_ctrl.reg_write;
    assign pc_en_o      = rst_ni & (w_ctrl.pc_write | (w_ctrl.branch & w_branch_cond));
    assign illegal_o    = r_illegal;
    assign state_o4     = r_state;

endmodule
